// File: rtl/execute_stage_pipe_if.sv
// rtl/execute_stage_pipe_if.sv - ID->EX handshake and payload bundle
interface execute_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int FUNC_W = 2
);
  // upstream (decode/control) side
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              RegWriteC;
  logic              MemWriteC;
  logic              MemToRegC;
  logic [FUNC_W-1:0] alufuncC;
  logic [DATA_W-1:0] srcDataD1;
  logic [DATA_W-1:0] srcDataD2;
  logic [ADDR_W-1:0] destAddD;

  // downstream (EX) side
  logic              out_valid;
  logic              out_ready;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              MemToRegE;
  logic [FUNC_W-1:0] alufuncE;
  logic [DATA_W-1:0] srcDataE1;
  logic [DATA_W-1:0] srcDataE2;
  logic [ADDR_W-1:0] destAddE;

  modport master (
    output flush, in_valid, RegWriteC, MemWriteC, MemToRegC, alufuncC,
           srcDataD1, srcDataD2, destAddD, out_ready,
    input  in_ready, out_valid, RegWriteE, MemWriteE, MemToRegE, alufuncE,
           srcDataE1, srcDataE2, destAddE
  );

  modport slave (
    input  flush, in_valid, RegWriteC, MemWriteC, MemToRegC, alufuncC,
           srcDataD1, srcDataD2, destAddD, out_ready,
    output in_ready, out_valid, RegWriteE, MemWriteE, MemToRegE, alufuncE,
           srcDataE1, srcDataE2, destAddE
  );
endinterface

// File: rtl/execute_stage_pipe.sv
// rtl/execute_stage_pipe.sv - ID->EX pipeline register with valid/ready, flush and optional skid entry
module execute_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int FUNC_W = 2,
  parameter int SKID   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  execute_stage_pipe_if.slave  bus,
  output logic [1:0]           occupancy
);

  // entry layout: {RegWrite, MemWrite, MemToReg, alufunc, src1, src2, dest}
  localparam int ENT_W = 3 + FUNC_W + 2 * DATA_W + ADDR_W;

  // state code doubles as the occupancy count
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [ENT_W-1:0] r_main;
  logic [ENT_W-1:0] r_skid;
  logic [ENT_W-1:0] w_main_nxt;
  logic [ENT_W-1:0] w_skid_nxt;
  logic [ENT_W-1:0] w_in_ent;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;

  assign w_in_ent = {bus.RegWriteC, bus.MemWriteC, bus.MemToRegC, bus.alufuncC,
                     bus.srcDataD1, bus.srcDataD2, bus.destAddD};

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop       = w_out_valid & bus.out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;

      // registered ready: the skid entry absorbs the one in-flight beat after a stall
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_FULL);
        end
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      // single entry: accept when the head is leaving or there is no head
      assign w_in_ready = bus.out_ready | ~w_out_valid;
    end
  endgenerate

  // next-state and datapath selection; flush beats both push and pop
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = w_in_ent;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt = w_in_ent;
          end else if (w_push && (SKID != 0)) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = w_in_ent;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  // state and entry registers; reset drops everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // head register drives EX directly; it is zeroed whenever the stage is empty
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign {bus.RegWriteE, bus.MemWriteE, bus.MemToRegE, bus.alufuncE,
          bus.srcDataE1, bus.srcDataE2, bus.destAddE} = r_main;
  assign occupancy = r_state;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb/tb_execute_stage_pipe.sv - randomized scoreboard bench for both skid variants
module tb_execute_stage_pipe;

  logic clk;
  logic reset;
  logic [1:0] occ1;
  logic [1:0] occ0;
  int n_checks;
  int n_fail;

  // bench view of an entry: {RegWrite, MemWrite, MemToReg, alufunc[1:0], src1[15:0], src2[15:0], dest[3:0]}
  logic [40:0] q1[$];
  logic [40:0] q0[$];

  execute_stage_pipe_if #(.DATA_W(16), .ADDR_W(4), .FUNC_W(2)) if1 ();
  execute_stage_pipe_if #(.DATA_W(16), .ADDR_W(4), .FUNC_W(2)) if0 ();

  execute_stage_pipe #(.DATA_W(16), .ADDR_W(4), .FUNC_W(2), .SKID(1)) u_d1 (
    .clk(clk), .reset(reset), .bus(if1), .occupancy(occ1));
  execute_stage_pipe #(.DATA_W(16), .ADDR_W(4), .FUNC_W(2), .SKID(0)) u_d0 (
    .clk(clk), .reset(reset), .bus(if0), .occupancy(occ0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] pk1();
    return {if1.RegWriteE, if1.MemWriteE, if1.MemToRegE, if1.alufuncE,
            if1.srcDataE1, if1.srcDataE2, if1.destAddE};
  endfunction

  function automatic logic [40:0] pk0();
    return {if0.RegWriteE, if0.MemWriteE, if0.MemToRegE, if0.alufuncE,
            if0.srcDataE1, if0.srcDataE2, if0.destAddE};
  endfunction

  function automatic logic [40:0] rand_ent();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[40:0];
  endfunction

  task automatic drive(input logic iv, input logic fl, input logic ordy, input logic [40:0] e);
    if1.in_valid = iv; if1.flush = fl; if1.out_ready = ordy;
    if0.in_valid = iv; if0.flush = fl; if0.out_ready = ordy;
    {if1.RegWriteC, if1.MemWriteC, if1.MemToRegC, if1.alufuncC,
     if1.srcDataD1, if1.srcDataD2, if1.destAddD} = e;
    {if0.RegWriteC, if0.MemWriteC, if0.MemToRegC, if0.alufuncC,
     if0.srcDataD1, if0.srcDataD2, if0.destAddD} = e;
  endtask

  // one cycle: starts and ends just after a falling edge; model is an in-order FIFO of capacity 2 (skid) / 1 (no skid)
  task automatic step(input logic iv, input logic fl, input logic ordy, input logic [40:0] e);
    logic rdy1, rdy0, v1, v0;
    drive(iv, fl, ordy, e);
    #1;
    v1   = (q1.size() > 0);
    v0   = (q0.size() > 0);
    rdy1 = (q1.size() < 2);
    rdy0 = ordy | ~v0;
    check_eq("d1_out_valid", if1.out_valid, v1);
    check_eq("d1_occupancy", occ1, q1.size());
    check_eq("d1_in_ready", if1.in_ready, rdy1);
    check_eq("d1_head", pk1(), v1 ? q1[0] : 41'd0);
    check_eq("d0_out_valid", if0.out_valid, v0);
    check_eq("d0_occupancy", occ0, q0.size());
    check_eq("d0_in_ready", if0.in_ready, rdy0);
    check_eq("d0_head", pk0(), v0 ? q0[0] : 41'd0);
    @(posedge clk);
    if (v1 && ordy) void'(q1.pop_front());
    if (v0 && ordy) void'(q0.pop_front());
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (iv && rdy1) q1.push_back(e);
      if (iv && rdy0) q0.push_back(e);
    end
    @(negedge clk);
  endtask

  logic [40:0] ent_a, ent_b, ent_c;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ent_a = {1'b1, 1'b0, 1'b0, 2'b01, 16'h1234, 16'h00aa, 4'h3};
    ent_b = {1'b1, 1'b1, 1'b0, 2'b10, 16'h5678, 16'h00bb, 4'h7};
    ent_c = {1'b1, 1'b1, 1'b1, 2'b11, 16'h9abc, 16'h00cc, 4'hc};

    // reset held with in_valid high: nothing may be captured
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, ent_a);
    repeat (3) @(negedge clk);
    check_eq("rst_d1_valid", if1.out_valid, 1'b0);
    check_eq("rst_d1_head", pk1(), 41'd0);
    check_eq("rst_d1_occ", occ1, 2'd0);
    check_eq("rst_d0_valid", if0.out_valid, 1'b0);
    check_eq("rst_d0_head", pk0(), 41'd0);
    drive(1'b0, 1'b0, 1'b0, 41'd0);
    reset = 1'b1;
    #1;
    check_eq("rst_d1_in_ready", if1.in_ready, 1'b1);
    check_eq("rst_d0_in_ready", if0.in_ready, 1'b1);
    @(negedge clk);

    // streaming A then B with EX always ready
    step(1'b1, 1'b0, 1'b1, ent_a);
    check_eq("stream_a_src1", if1.srcDataE1, 16'h1234);
    check_eq("stream_a_dest", if1.destAddE, 4'h3);
    step(1'b1, 1'b0, 1'b1, ent_b);
    check_eq("stream_b_src1", if1.srcDataE1, 16'h5678);
    step(1'b0, 1'b0, 1'b1, 41'd0);
    step(1'b0, 1'b0, 1'b1, 41'd0);

    // back-pressure fills the skid entry
    step(1'b1, 1'b0, 1'b0, ent_a);
    step(1'b1, 1'b0, 1'b0, ent_b);
    check_eq("bp_occ_full", occ1, 2'd2);
    check_eq("bp_in_ready_low", if1.in_ready, 1'b0);
    check_eq("bp_hold_a", if1.srcDataE1, 16'h1234);
    step(1'b1, 1'b0, 1'b0, ent_c);
    step(1'b0, 1'b0, 1'b1, 41'd0);
    step(1'b0, 1'b0, 1'b1, 41'd0);
    step(1'b0, 1'b0, 1'b1, 41'd0);
    check_eq("bp_drained_occ", occ1, 2'd0);

    // flush while full, with a simultaneous push of C
    step(1'b1, 1'b0, 1'b0, ent_a);
    step(1'b1, 1'b0, 1'b0, ent_b);
    step(1'b1, 1'b1, 1'b0, ent_c);
    check_eq("flush_valid", if1.out_valid, 1'b0);
    check_eq("flush_occ", occ1, 2'd0);
    check_eq("flush_regwrite", if1.RegWriteE, 1'b0);
    check_eq("flush_memwrite", if1.MemWriteE, 1'b0);
    step(1'b0, 1'b0, 1'b1, 41'd0);
    step(1'b0, 1'b0, 1'b1, 41'd0);

    // single-entry variant: stall with A, then replace with B in the same edge
    step(1'b1, 1'b0, 1'b0, ent_a);
    step(1'b0, 1'b0, 1'b0, 41'd0);
    check_eq("s0_hold_a", if0.srcDataE1, 16'h1234);
    step(1'b1, 1'b0, 1'b1, ent_b);
    check_eq("s0_b_next", if0.srcDataE1, 16'h5678);
    step(1'b1, 1'b1, 1'b0, 41'd0);

    // randomized valid/ready/flush
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 9) < 6), rand_ent());
    end

    // asynchronous reset in the middle of operation
    step(1'b1, 1'b0, 1'b0, ent_a);
    step(1'b1, 1'b0, 1'b0, ent_b);
    drive(1'b0, 1'b0, 1'b0, 41'd0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_d1_valid", if1.out_valid, 1'b0);
    check_eq("mid_rst_d1_occ", occ1, 2'd0);
    check_eq("mid_rst_d1_head", pk1(), 41'd0);
    check_eq("mid_rst_d0_valid", if0.out_valid, 1'b0);
    check_eq("mid_rst_d0_head", pk0(), 41'd0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1, ent_c);
    step(1'b0, 1'b0, 1'b1, 41'd0);
    step(1'b0, 1'b0, 1'b1, 41'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
